// File: rtl/tone_if.sv
// Tone generator signal bundle: note index in, square wave and filtered note status out.
interface tone_if;
  logic [4:0] notecode;
  logic       audio_out;
  logic [4:0] current_note;
  logic       note_active;

  modport master (output notecode, input audio_out, current_note, note_active);
  modport slave  (input notecode, output audio_out, current_note, note_active);
endinterface

// File: rtl/tone_generator.sv
// Debounces the key-encoder note index, then drives a 50% square wave whose
// half period comes from a C4..B6 lookup table in clk_5MHz cycles.
module tone_generator #(
  parameter int unsigned STABLE_CYCLES = 5000
) (
  input  logic   clk_5MHz,
  input  logic   rst,
  tone_if.slave  tif
);

  localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);

  logic [4:0]  mapped;
  logic [4:0]  cand_q, cand_d;
  logic [15:0] stab_q, stab_d;
  logic [4:0]  cur_q, cur_d;
  logic [13:0] phase_q, phase_d;
  logic [13:0] half;
  logic        audio_q, audio_d;
  logic        active_q, active_d;

  function automatic logic [13:0] half_of(input logic [4:0] n);
    case (n)
      5'd1:  half_of = 14'd9556;
      5'd2:  half_of = 14'd8513;
      5'd3:  half_of = 14'd7584;
      5'd4:  half_of = 14'd7159;
      5'd5:  half_of = 14'd6378;
      5'd6:  half_of = 14'd5682;
      5'd7:  half_of = 14'd5062;
      5'd8:  half_of = 14'd4778;
      5'd9:  half_of = 14'd4257;
      5'd10: half_of = 14'd3792;
      5'd11: half_of = 14'd3579;
      5'd12: half_of = 14'd3189;
      5'd13: half_of = 14'd2841;
      5'd14: half_of = 14'd2531;
      5'd15: half_of = 14'd2389;
      5'd16: half_of = 14'd2128;
      5'd17: half_of = 14'd1896;
      5'd18: half_of = 14'd1790;
      5'd19: half_of = 14'd1594;
      5'd20: half_of = 14'd1420;
      5'd21: half_of = 14'd1265;
      default: half_of = 14'd0;
    endcase
  endfunction

  always_comb begin
    mapped = (tif.notecode > 5'd21) ? 5'd0 : tif.notecode;
    cand_d = cand_q;
    stab_d = stab_q;
    cur_d  = cur_q;

    if (mapped != cand_q) begin
      cand_d = mapped;
      stab_d = 16'd1;
    end else if (stab_q < STABLE) begin
      stab_d = stab_q + 16'd1;
    end

    // The count only equals STABLE with a fresh candidate on the edge it
    // first gets there; afterwards cand == cur, so re-stabilising is a no-op.
    if (stab_d == STABLE && cand_d != cur_q)
      cur_d = cand_d;

    active_d = (cur_d != 5'd0);

    half    = half_of(cur_q);
    phase_d = phase_q + 14'd1;
    audio_d = audio_q;
    if (cur_d != cur_q || cur_q == 5'd0) begin
      phase_d = 14'd0;
      audio_d = 1'b0;
    end else if (phase_q == half - 14'd1) begin
      phase_d = 14'd0;
      audio_d = ~audio_q;
    end
  end

  always_ff @(posedge clk_5MHz or posedge rst) begin
    if (rst) begin
      cand_q   <= 5'd0;
      stab_q   <= 16'd0;
      cur_q    <= 5'd0;
      phase_q  <= 14'd0;
      audio_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      cur_q    <= cur_d;
      phase_q  <= phase_d;
      audio_q  <= audio_d;
      active_q <= active_d;
    end
  end

  assign tif.audio_out    = audio_q;
  assign tif.current_note = cur_q;
  assign tif.note_active  = active_q;

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator: directed note scenarios plus random note bursts,
// checked every edge against a run-length / elapsed-time model of the tone.
module tb_tone_generator;

  localparam int STABLE = 4;

  logic clk_5MHz = 1'b0;
  logic rst      = 1'b0;

  tone_if tif();

  tone_generator #(.STABLE_CYCLES(STABLE)) dut (
    .clk_5MHz (clk_5MHz),
    .rst      (rst),
    .tif      (tif)
  );

  always #5 clk_5MHz = ~clk_5MHz;

  int n_checks = 0;
  int n_errors = 0;

  int half_tab [22] = '{0,
                        9556, 8513, 7584, 7159, 6378, 5682, 5062,
                        4778, 4257, 3792, 3579, 3189, 2841, 2531,
                        2389, 2128, 1896, 1790, 1594, 1420, 1265};

  // Model: length of the current run of identical samples, the adopted note,
  // and the edge it was adopted on; audio is derived from elapsed edges.
  int run_val = 0;
  int run_len = 0;
  int m_cur   = 0;
  int t0      = 0;
  int cyc     = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int exp_audio();
    if (m_cur == 0) return 0;
    return ((cyc - t0) / half_tab[m_cur]) % 2;
  endfunction

  task automatic model_reset();
    run_val = 0;
    run_len = 0;
    m_cur   = 0;
  endtask

  task automatic step();
    int m;
    @(posedge clk_5MHz);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      m = (int'(tif.notecode) > 21) ? 0 : int'(tif.notecode);
      if (m == run_val) run_len++;
      else begin
        run_val = m;
        run_len = 1;
      end
      if (run_len == STABLE && run_val != m_cur) begin
        m_cur = run_val;
        t0    = cyc;
      end
    end
    #1;
    check_val("current_note", int'(tif.current_note), m_cur);
    check_val("note_active", int'(tif.note_active), (m_cur != 0) ? 1 : 0);
    check_val("audio_out", int'(tif.audio_out), exp_audio());
  endtask

  task automatic hold(input int note, input int n);
    tif.notecode = 5'(note);
    repeat (n) step();
  endtask

  initial begin
    int note;
    int len;
    bit seen_high;

    tif.notecode = 5'd0;
    #1 rst = 1'b1;
    #1;
    check_val("reset_current_note", int'(tif.current_note), 0);
    check_val("reset_audio", int'(tif.audio_out), 0);
    check_val("reset_active", int'(tif.note_active), 0);
    repeat (2) step();
    rst = 1'b0;

    // Note 6 from reset: adopted on 4th edge, two full half-periods observed.
    tif.notecode = 5'd6;
    repeat (3) step();
    check_val("n6_not_before_4th", int'(tif.current_note), 0);
    step();
    check_val("n6_adopt_4th", int'(tif.current_note), 6);
    check_val("n6_active", int'(tif.note_active), 1);
    hold(6, 11400);

    // Note 1 with a 3-edge excursion to 15.
    hold(1, 6000);
    hold(15, 3);
    hold(1, 6000);
    check_val("glitch_keeps_note", int'(tif.current_note), 1);

    // Switch to 8 while audio is high.
    seen_high = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (tif.audio_out) begin
        seen_high = 1'b1;
        break;
      end
      step();
    end
    check_val("wait_audio_high", int'(seen_high), 1);
    hold(8, 4);
    check_val("switch_audio_zero", int'(tif.audio_out), 0);
    check_val("switch_note", int'(tif.current_note), 8);
    hold(8, 4800);

    // Highest note, then an out-of-range code that maps to silence.
    hold(21, 3000);
    hold(25, 4);
    check_val("map25_note", int'(tif.current_note), 0);
    check_val("map25_audio", int'(tif.audio_out), 0);
    check_val("map25_active", int'(tif.note_active), 0);
    hold(25, 6);

    // Short release to 0 and back: phase continues.
    hold(5, 5000);
    hold(0, 3);
    hold(5, 5000);

    // Random note bursts, mostly short with occasional long holds.
    for (int s = 0; s < 16; s++) begin
      note = $urandom_range(0, 31);
      len  = ($urandom_range(0, 3) == 0) ? $urandom_range(300, 2000) : $urandom_range(1, 6);
      hold(note, len);
    end

    // Asynchronous reset mid-tone, then refilter from scratch.
    hold(10, 3000);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_audio", int'(tif.audio_out), 0);
    check_val("async_rst_note", int'(tif.current_note), 0);
    check_val("async_rst_active", int'(tif.note_active), 0);
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    tif.notecode = 5'd3;
    repeat (3) step();
    check_val("post_rst_no_early", int'(tif.current_note), 0);
    step();
    check_val("post_rst_adopt_4th", int'(tif.current_note), 3);
    hold(3, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
